log_shift_unit: RTL

//  Sequential logic/shift unit for the MSP430 execution datapath. It extends the

---
 rtl/log_shift_unit.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/log_shift_unit.sv
// MSP430-style logic/shift unit: single-cycle logic ops and SWPB, bit-serial RRA/RRC/RLA,
// registered result and {V,N,Z,C} flags behind valid/ready handshakes on both sides.
module log_shift_unit #(
  parameter int unsigned SIZE  = 16,
  parameter int unsigned CNT_W = $clog2(SIZE)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [SIZE-1:0]  i_src,
  input  logic [SIZE-1:0]  i_dst,
  input  logic [3:0]       i_fs,
  input  logic             i_bw,
  input  logic [CNT_W-1:0] i_shamt,
  input  logic             i_c_in,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [SIZE-1:0]  o_result,
  output logic [3:0]       o_flags
);

  localparam int unsigned HALF = SIZE / 2;
  localparam logic [SIZE-1:0] BYTE_MASK = SIZE'(8'hFF);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e           r_state, w_state_d;
  logic [SIZE-1:0]  r_w, w_w_d;
  logic [CNT_W-1:0] r_cnt, w_cnt_d;
  logic             r_k, w_k_d;
  logic [1:0]       r_op, w_op_d;
  logic             r_bw, w_bw_d;
  logic [SIZE-1:0]  r_result, w_result_d;
  logic [3:0]       r_flags, w_flags_d;

  logic [SIZE-1:0]  w_a_raw, w_a, w_b;
  logic             w_swpb, w_starts_shift;
  logic [SIZE-1:0]  w_acc_res;
  logic             w_acc_v, w_acc_n, w_acc_z, w_acc_c;
  logic [SIZE-1:0]  w_sh;
  logic             w_k_sh, w_msb, w_ins;

  function automatic logic msb_of(input logic [SIZE-1:0] v, input logic bw);
    return bw ? v[7] : v[SIZE-1];
  endfunction

  assign w_a_raw        = i_fs[3] ? ~i_src : i_src;
  assign w_a            = i_bw ? (w_a_raw & BYTE_MASK) : w_a_raw;
  assign w_b            = i_bw ? (i_dst & BYTE_MASK) : i_dst;
  assign w_swpb         = (i_fs[2:0] == 3'b111);
  assign w_starts_shift = i_fs[2] && !w_swpb && (i_shamt != '0);

  // Result and flags for everything that finishes in the accept cycle.
  always_comb begin
    w_acc_res = w_a;
    if (w_swpb) begin
      // SWPB ignores byte mode, so it works on the unmasked operand.
      w_acc_res = {w_a_raw[HALF-1:0], w_a_raw[SIZE-1:HALF]};
    end else if (!i_fs[2]) begin
      unique case (i_fs[1:0])
        2'b00:   w_acc_res = w_a & w_b;
        2'b01:   w_acc_res = w_a | w_b;
        2'b10:   w_acc_res = w_a ^ w_b;
        default: w_acc_res = w_a;
      endcase
    end
    w_acc_z = (w_acc_res == '0);
    w_acc_n = w_swpb ? w_acc_res[SIZE-1] : msb_of(w_acc_res, i_bw);
    w_acc_c = i_c_in;
    if (!i_fs[2] && !i_fs[0]) begin
      w_acc_c = ~w_acc_z;
    end
    w_acc_v = 1'b0;
    if (!i_fs[2] && (i_fs[1:0] == 2'b10)) begin
      w_acc_v = msb_of(w_a, i_bw) & msb_of(w_b, i_bw);
    end
  end

  // One-bit step of the work register during SHIFT.
  always_comb begin
    w_sh   = r_w;
    w_k_sh = r_k;
    w_ins  = 1'b0;
    w_msb  = msb_of(r_w, r_bw);
    unique case (r_op)
      2'b00, 2'b01: begin
        w_sh  = r_w >> 1;
        w_ins = (r_op == 2'b00) ? w_msb : r_k;
        if (r_bw) begin
          w_sh[7] = w_ins;
        end else begin
          w_sh[SIZE-1] = w_ins;
        end
        w_k_sh = r_w[0];
      end
      2'b10: begin
        w_sh = r_w << 1;
        if (r_bw) begin
          w_sh = w_sh & BYTE_MASK;
        end
        w_k_sh = w_msb;
      end
      default: begin
        w_sh   = r_w;
        w_k_sh = r_k;
      end
    endcase
  end

  always_comb begin
    w_state_d  = r_state;
    w_w_d      = r_w;
    w_cnt_d    = r_cnt;
    w_k_d      = r_k;
    w_op_d     = r_op;
    w_bw_d     = r_bw;
    w_result_d = r_result;
    w_flags_d  = r_flags;
    unique case (r_state)
      StIdle: begin
        if (i_in_valid) begin
          w_w_d   = w_a;
          w_cnt_d = i_shamt;
          w_op_d  = i_fs[1:0];
          w_bw_d  = i_bw;
          if (w_starts_shift) begin
            w_k_d     = i_c_in;
            w_state_d = StShift;
          end else begin
            w_result_d = w_acc_res;
            w_flags_d  = {w_acc_v, w_acc_n, w_acc_z, w_acc_c};
            w_state_d  = StDone;
          end
        end
      end
      StShift: begin
        w_w_d   = w_sh;
        w_k_d   = w_k_sh;
        w_cnt_d = r_cnt - 1'b1;
        if (r_cnt == CNT_W'(1)) begin
          w_result_d = w_sh;
          w_flags_d  = {1'b0, msb_of(w_sh, r_bw), (w_sh == '0), w_k_sh};
          w_state_d  = StDone;
        end
      end
      StDone: begin
        if (i_out_ready) begin
          w_state_d = StIdle;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= StIdle;
      r_w      <= '0;
      r_cnt    <= '0;
      r_k      <= 1'b0;
      r_op     <= 2'b00;
      r_bw     <= 1'b0;
      r_result <= '0;
      r_flags  <= 4'b0000;
    end else begin
      r_state  <= w_state_d;
      r_w      <= w_w_d;
      r_cnt    <= w_cnt_d;
      r_k      <= w_k_d;
      r_op     <= w_op_d;
      r_bw     <= w_bw_d;
      r_result <= w_result_d;
      r_flags  <= w_flags_d;
    end
  end

  assign o_in_ready  = (r_state == StIdle);
  assign o_out_valid = (r_state == StDone);
  assign o_result    = r_result;
  assign o_flags     = r_flags;

endmodule
